// File: rtl/decode_stage_sb_if.sv
// decode_stage_sb_if: fetch-side bundle of the decode stage.
// Fetch drives instruction/control; decode answers with stall.
interface decode_stage_sb_if;
  logic [15:0] instr_in;
  logic [15:0] pc_in;
  logic        bubble_in;
  logic        flush;
  logic        halt;
  logic        stall;

  modport master (
    output instr_in, pc_in, bubble_in, flush, halt,
    input  stall
  );

  modport slave (
    input  instr_in, pc_in, bubble_in, flush, halt,
    output stall
  );
endinterface

// File: rtl/decode_stage_sb.sv
// decode_stage_sb: 16-bit ISA decode with load scoreboard,
// skid FIFO for in-flight fetches and optional write bypass.
module decode_stage_sb #(
  parameter int DATA_W     = 16,
  parameter int LOAD_LAT   = 1,
  parameter int SKID_DEPTH = 2,
  parameter int BYPASS     = 1,
  parameter int RET_REG    = 1
) (
  input  logic              clk,
  input  logic              rst,
  decode_stage_sb_if.slave  fe,
  input  logic              we,
  input  logic [2:0]        target,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] d_1,
  output logic [DATA_W-1:0] d_2,
  output logic [15:0]       pc_out,
  output logic [2:0]        opcode_out,
  output logic [2:0]        s_1_out,
  output logic [2:0]        s_2_out,
  output logic [2:0]        tgt_out,
  output logic [3:0]        alu_op_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [5:0]        branch_code_out,
  output logic              bubble_out,
  output logic              halt_out,
  output logic [DATA_W-1:0] ret_val,
  output logic              skid_ovf
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [CW-1:0] FULL  = CW'(SKID_DEPTH);
  localparam logic [PW-1:0] LASTP = PW'(SKID_DEPTH - 1);

  localparam logic [2:0] OP_LUI = 3'b011;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;
  localparam logic [2:0] OP_BR  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  logic [DATA_W-1:0] rf_q [8];
  logic [2:0]        sb_q [LOAD_LAT];
  logic [15:0]       fi_q [SKID_DEPTH];
  logic [15:0]       fp_q [SKID_DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q;

  logic [DATA_W-1:0] d1_q, d2_q, imm_q;
  logic [15:0]       pc_q;
  logic [2:0]        op_q, s1_q, s2_q, tgt_q;
  logic [3:0]        alu_q;
  logic [5:0]        bc_q;
  logic              bub_q, hlt_q;

  logic              src_v;
  logic [15:0]       src_i, src_pc;
  logic [2:0]        op, s1, s2, tgt;
  logic [DATA_W-1:0] imm, rd1, rd2;
  logic              hazard, issue, pop, push_req, push, full;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LASTP) ? '0 : p + 1'b1;
  endfunction

  // Buffered instructions always take priority over the fetch port.
  always_comb begin
    src_v  = !fe.bubble_in;
    src_i  = fe.instr_in;
    src_pc = fe.pc_in;
    if (cnt_q != '0) begin
      src_v  = 1'b1;
      src_i  = fi_q[head_q];
      src_pc = fp_q[head_q];
    end
  end

  assign op = src_i[15:13];
  assign s1 = src_i[9:7];
  assign s2 = (op == OP_SW) ? src_i[12:10] : src_i[2:0];

  always_comb begin
    tgt = src_i[12:10];
    imm = DATA_W'($signed(src_i[6:0]));
    unique case (1'b1)
      (op == OP_SW), (op == OP_BR): tgt = 3'd0;
      (op == OP_LUI): imm = DATA_W'({src_i[9:0], 6'b000000});
      default: ;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_q[i] != 3'd0 && (sb_q[i] == s1 || sb_q[i] == s2))
        hazard = 1'b1;
    end
    hazard = hazard & src_v;
  end

  assign full     = (cnt_q == FULL);
  assign issue    = src_v & !hazard & !fe.halt & !fe.flush;
  assign pop      = issue & (cnt_q != '0);
  assign push_req = !fe.bubble_in & !fe.flush
                  & !(issue & (cnt_q == '0));
  assign push     = push_req & !full;
  assign fe.stall = hazard | (cnt_q != '0);

  always_comb begin
    rd1 = rf_q[s1];
    rd2 = rf_q[s2];
    if (BYPASS != 0 && we) begin
      if (target == s1) rd1 = write_data;
      if (target == s2) rd2 = write_data;
    end
    if (s1 == 3'd0) rd1 = '0;
    if (s2 == 3'd0) rd2 = '0;
  end

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (fe.flush) begin
      cnt_d  = '0;
      head_d = '0;
      tail_d = '0;
    end else begin
      if (pop)  head_d = nxt(head_q);
      if (push) tail_d = nxt(tail_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        fi_q[i] <= '0;
        fp_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      if (push_req && full) ovf_q <= 1'b1;
      if (push) begin
        fi_q[tail_q] <= fe.instr_in;
        fp_q[tail_q] <= fe.pc_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (we && target != 3'd0) begin
      rf_q[target] <= write_data;
    end
  end

  // Loads already issued keep draining through flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOAD_LAT; i++) sb_q[i] <= '0;
    end else if (!fe.halt) begin
      sb_q[0] <= (issue && op == OP_LW) ? tgt : 3'd0;
      for (int i = 1; i < LOAD_LAT; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q  <= '0;
      d2_q  <= '0;
      imm_q <= '0;
      pc_q  <= '0;
      op_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      tgt_q <= '0;
      alu_q <= '0;
      bc_q  <= '0;
      bub_q <= 1'b1;
      hlt_q <= 1'b0;
    end else if (!fe.halt) begin
      if (issue) begin
        d1_q  <= rd1;
        d2_q  <= rd2;
        imm_q <= imm;
        pc_q  <= src_pc;
        op_q  <= op;
        s1_q  <= s1;
        s2_q  <= s2;
        tgt_q <= tgt;
        alu_q <= src_i[6:3];
        bc_q  <= src_i[12:7];
        bub_q <= 1'b0;
        hlt_q <= (op == OP_HLT) && (src_i[6:0] != 7'd0);
      end else begin
        tgt_q <= '0;
        bub_q <= 1'b1;
        hlt_q <= 1'b0;
      end
    end
  end

  assign d_1             = d1_q;
  assign d_2             = d2_q;
  assign imm_out         = imm_q;
  assign pc_out          = pc_q;
  assign opcode_out      = op_q;
  assign s_1_out         = s1_q;
  assign s_2_out         = s2_q;
  assign tgt_out         = tgt_q;
  assign alu_op_out      = alu_q;
  assign branch_code_out = bc_q;
  assign bubble_out      = bub_q;
  assign halt_out        = hlt_q;
  assign skid_ovf        = ovf_q;
  assign ret_val         = rf_q[3'(RET_REG)];

endmodule

// File: tb/tb_decode_stage_sb.sv
// tb_decode_stage_sb: directed and random checks of decode_stage_sb
// against a queue-based reference model (LOAD_LAT=2, 2-deep skid).
module tb_decode_stage_sb;
  localparam int DW = 16;
  localparam int LL = 2;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst;
  logic we;
  logic [2:0] target;
  logic [DW-1:0] wd;

  decode_stage_sb_if ifa ();
  decode_stage_sb_if ifb ();

  assign ifb.instr_in  = ifa.instr_in;
  assign ifb.pc_in     = ifa.pc_in;
  assign ifb.bubble_in = ifa.bubble_in;
  assign ifb.flush     = ifa.flush;
  assign ifb.halt      = ifa.halt;

  logic [DW-1:0] d1, d2, imm, rv, b_d1, b_d2, b_imm, b_rv;
  logic [15:0] pco, b_pco;
  logic [2:0] opc, s1o, s2o, tgo, b_opc, b_s1o, b_s2o, b_tgo;
  logic [3:0] alu, b_alu;
  logic [5:0] bc, b_bc;
  logic bub, hlo, ovf, b_bub, b_hlo, b_ovf;

  decode_stage_sb #(.DATA_W(DW), .LOAD_LAT(LL), .SKID_DEPTH(SD),
                    .BYPASS(1), .RET_REG(1)) dut (
    .clk(clk), .rst(rst), .fe(ifa.slave),
    .we(we), .target(target), .write_data(wd),
    .d_1(d1), .d_2(d2), .pc_out(pco), .opcode_out(opc),
    .s_1_out(s1o), .s_2_out(s2o), .tgt_out(tgo), .alu_op_out(alu),
    .imm_out(imm), .branch_code_out(bc), .bubble_out(bub),
    .halt_out(hlo), .ret_val(rv), .skid_ovf(ovf)
  );

  decode_stage_sb #(.DATA_W(DW), .LOAD_LAT(LL), .SKID_DEPTH(SD),
                    .BYPASS(0), .RET_REG(1)) dut_nb (
    .clk(clk), .rst(rst), .fe(ifb.slave),
    .we(we), .target(target), .write_data(wd),
    .d_1(b_d1), .d_2(b_d2), .pc_out(b_pco), .opcode_out(b_opc),
    .s_1_out(b_s1o), .s_2_out(b_s2o), .tgt_out(b_tgo), .alu_op_out(b_alu),
    .imm_out(b_imm), .branch_code_out(b_bc), .bubble_out(b_bub),
    .halt_out(b_hlo), .ret_val(b_rv), .skid_ovf(b_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [15:0] mrf [8];
  logic [31:0] mq [$];
  int pr [$];
  int pa [$];
  logic hv, hz, e_stall;
  logic [15:0] hi, hp;
  logic e_bub, e_hlt, e_ovf;
  logic [2:0] e_op, e_s1, e_s2, e_tgt;
  logic [3:0] e_alu;
  logic [5:0] e_bc;
  logic [15:0] e_imm, e_pc, e_d1, e_d2, eb_d1;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [15:0] ins(input logic [2:0] op, input logic [2:0] t,
                                      input logic [2:0] a, input logic [3:0] f,
                                      input logic [2:0] b);
    return {op, t, a, f, b};
  endfunction

  function automatic int src2(input logic [15:0] x);
    return (x[15:13] == 3'b100) ? int'(x[12:10]) : int'(x[2:0]);
  endfunction

  function automatic logic [15:0] mrd(input int a, input bit byp);
    if (a == 0) return 16'h0;
    if (byp && we && int'(target) == a) return wd;
    return mrf[a];
  endfunction

  task automatic mreset();
    for (int k = 0; k < 8; k++) mrf[k] = 16'h0;
    mq.delete(); pr.delete(); pa.delete();
    e_bub = 1'b1; e_hlt = 1'b0; e_ovf = 1'b0;
    e_op = 3'd0; e_s1 = 3'd0; e_s2 = 3'd0; e_tgt = 3'd0;
    e_alu = 4'd0; e_bc = 6'd0; e_imm = 16'h0; e_pc = 16'h0;
    e_d1 = 16'h0; e_d2 = 16'h0; eb_d1 = 16'h0;
  endtask

  task automatic mcomb();
    hv = (mq.size() > 0) || !ifa.bubble_in;
    if (mq.size() > 0) begin
      hi = mq[0][31:16]; hp = mq[0][15:0];
    end else begin
      hi = ifa.instr_in; hp = ifa.pc_in;
    end
    hz = 1'b0;
    foreach (pr[k])
      if (pr[k] != 0 && (pr[k] == int'(hi[9:7]) || pr[k] == src2(hi))) hz = hv;
    e_stall = hz || (mq.size() != 0);
  endtask

  task automatic mstep();
    bit iss, pushr;
    int n;
    mcomb();
    n = mq.size();
    iss = hv && !hz && !ifa.halt && !ifa.flush;
    if (!ifa.halt) begin
      if (iss) begin
        e_bub = 1'b0;
        e_op  = hi[15:13];
        e_s1  = hi[9:7];
        e_s2  = 3'(src2(hi));
        e_alu = hi[6:3];
        e_bc  = hi[12:7];
        e_pc  = hp;
        e_tgt = (e_op == 3'b100 || e_op == 3'b110) ? 3'd0 : hi[12:10];
        e_imm = (e_op == 3'b011) ? {hi[9:0], 6'b000000} : {{9{hi[6]}}, hi[6:0]};
        e_hlt = (e_op == 3'b111) && (hi[6:0] != 7'd0);
        e_d1  = mrd(int'(e_s1), 1'b1);
        e_d2  = mrd(int'(e_s2), 1'b1);
        eb_d1 = mrd(int'(e_s1), 1'b0);
      end else begin
        e_bub = 1'b1; e_tgt = 3'd0; e_hlt = 1'b0;
      end
      for (int k = pr.size() - 1; k >= 0; k--) begin
        pa[k] = pa[k] + 1;
        if (pa[k] >= LL) begin pr.delete(k); pa.delete(k); end
      end
      if (iss && hi[15:13] == 3'b101) begin
        pr.push_back(int'(hi[12:10])); pa.push_back(0);
      end
    end
    if (ifa.flush) mq.delete();
    else begin
      pushr = !ifa.bubble_in && !(iss && n == 0);
      if (iss && n > 0) void'(mq.pop_front());
      if (pushr) begin
        if (n == SD) e_ovf = 1'b1;
        else mq.push_back({ifa.instr_in, ifa.pc_in});
      end
    end
    if (we && target != 3'd0) mrf[target] = wd;
  endtask

  task automatic chk_outs();
    chk("bubble_out", 32'(bub), 32'(e_bub));
    chk("tgt_out", 32'(tgo), 32'(e_tgt));
    chk("halt_out", 32'(hlo), 32'(e_hlt));
    chk("skid_ovf", 32'(ovf), 32'(e_ovf));
    chk("ret_val", 32'(rv), 32'(mrf[1]));
    if (!e_bub) begin
      chk("opcode_out", 32'(opc), 32'(e_op));
      chk("s_1_out", 32'(s1o), 32'(e_s1));
      chk("s_2_out", 32'(s2o), 32'(e_s2));
      chk("alu_op_out", 32'(alu), 32'(e_alu));
      chk("branch_code", 32'(bc), 32'(e_bc));
      chk("imm_out", 32'(imm), 32'(e_imm));
      chk("pc_out", 32'(pco), 32'(e_pc));
      chk("d_1", 32'(d1), 32'(e_d1));
      chk("d_2", 32'(d2), 32'(e_d2));
      chk("nb_d_1", 32'(b_d1), 32'(eb_d1));
    end
  endtask

  // one clock: check stall mid-cycle, advance model, check outputs
  task automatic cyc();
    #2;
    if (!rst) begin
      mcomb();
      chk("stall", 32'(ifa.stall), 32'(e_stall));
      chk("nb_stall", 32'(ifb.stall), 32'(e_stall));
      mstep();
    end
    @(posedge clk);
    #1;
    if (rst) mreset();
    chk_outs();
  endtask

  task automatic drv(input bit b, input logic [15:0] i, input logic [15:0] p);
    ifa.bubble_in = b; ifa.instr_in = i; ifa.pc_in = p;
  endtask

  function automatic logic [15:0] rnd_ins();
    logic [15:0] x;
    x = 16'($urandom);
    if ($urandom_range(0, 2) == 0) x[15:13] = 3'b101;
    return x;
  endfunction

  initial begin
    rst = 1'b1; we = 1'b0; target = 3'd0; wd = 16'h0;
    ifa.flush = 1'b0; ifa.halt = 1'b0;
    drv(1'b1, 16'h0, 16'h0);
    cyc();
    rst = 1'b0;
    chk("rst_bubble", 32'(bub), 32'd1);
    for (int k = 0; k < 4; k++) cyc();
    chk("idle_stall", 32'(ifa.stall), 32'd0);

    // load-use: lw r2 then add r3,r2,r1
    drv(1'b0, ins(3'b101, 3'd2, 3'd0, 4'd0, 3'd0), 16'h0010); cyc();
    drv(1'b0, ins(3'b000, 3'd3, 3'd2, 4'd0, 3'd1), 16'h0012); cyc();
    chk("t2_bub1", 32'(bub), 32'd1);
    drv(1'b1, 16'h0, 16'h0); cyc();
    chk("t2_bub2", 32'(bub), 32'd1);
    cyc();
    chk("t2_add_valid", 32'(bub), 32'd0);
    chk("t2_add_s1", 32'(s1o), 32'd2);
    chk("t2_add_pc", 32'(pco), 32'h12);
    for (int k = 0; k < 3; k++) cyc();

    // two fetches in flight during a load-use stall
    drv(1'b0, ins(3'b101, 3'd2, 3'd0, 4'd0, 3'd0), 16'h0020); cyc();
    drv(1'b0, ins(3'b000, 3'd3, 3'd2, 4'd1, 3'd1), 16'h0022); cyc();
    drv(1'b0, ins(3'b000, 3'd5, 3'd2, 4'd2, 3'd4), 16'h0024); cyc();
    drv(1'b1, 16'h0, 16'h0);
    for (int k = 0; k < 4; k++) cyc();
    chk("t3_no_ovf", 32'(ovf), 32'd0);

    // bypass: write r4 while reading it
    we = 1'b1; target = 3'd4; wd = 16'h1111; cyc();
    wd = 16'h1234;
    drv(1'b0, ins(3'b000, 3'd0, 3'd4, 4'd0, 3'd0), 16'h0030); cyc();
    we = 1'b0; drv(1'b1, 16'h0, 16'h0);
    chk("t4_bypass", 32'(d1), 32'h1234);
    chk("t4_nobypass", 32'(b_d1), 32'h1111);
    cyc();

    // flush with two buffered entries
    ifa.halt = 1'b1;
    drv(1'b0, ins(3'b001, 3'd1, 3'd1, 4'd3, 3'd1), 16'h0040); cyc();
    drv(1'b0, ins(3'b001, 3'd6, 3'd1, 4'd3, 3'd1), 16'h0042); cyc();
    ifa.halt = 1'b0; ifa.flush = 1'b1; drv(1'b1, 16'h0, 16'h0); cyc();
    ifa.flush = 1'b0;
    chk("t5_bubble", 32'(bub), 32'd1);
    chk("t5_stall", 32'(ifa.stall), 32'd0);
    cyc();

    // overflow of the 2-deep skid, then reset mid-stall
    ifa.halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, ins(3'b010, 3'(k + 1), 3'd0, 4'd5, 3'd0), 16'(16'h50 + 2 * k));
      cyc();
    end
    chk("t6_ovf", 32'(ovf), 32'd1);
    ifa.halt = 1'b0; drv(1'b1, 16'h0, 16'h0);
    for (int k = 0; k < 3; k++) cyc();
    chk("t6_ovf_sticky", 32'(ovf), 32'd1);
    ifa.halt = 1'b1; drv(1'b0, ins(3'b010, 3'd7, 3'd0, 4'd0, 3'd0), 16'h60); cyc();
    rst = 1'b1; cyc(); rst = 1'b0; ifa.halt = 1'b0; drv(1'b1, 16'h0, 16'h0);
    chk("t6_rst_ovf", 32'(ovf), 32'd0);
    chk("t6_rst_bub", 32'(bub), 32'd1);
    chk("t6_rst_tgt", 32'(tgo), 32'd0);
    cyc();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drv($urandom_range(0, 9) < 3, rnd_ins(), 16'($urandom));
      ifa.flush = ($urandom_range(0, 19) == 0);
      ifa.halt  = ($urandom_range(0, 9) == 0);
      we        = ($urandom_range(0, 9) < 4);
      target    = 3'($urandom);
      wd        = 16'($urandom);
      rst       = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
